// File: rtl/fp32_pkg.sv
// Shared binary32 definitions for the add/compare pipeline: field widths,
// canonical special encodings, the operation select and field classifiers.
package fp32_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_EQ   = 2'd1,
        OP_LT   = 2'd2,
        OP_RSVD = 2'd3
    } fp_op_e;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

    function automatic logic is_nan(input fp32_t x);
        return (x.exp == '1) && (x.man != '0);
    endfunction

    function automatic logic is_inf(input fp32_t x);
        return (x.exp == '1) && (x.man == '0);
    endfunction

    // Subnormals are flushed, so any zero exponent reads as a signed zero.
    function automatic logic is_zero(input fp32_t x);
        return (x.exp == '0);
    endfunction

endpackage

// File: rtl/fp32_add_cmp_pipe_if.sv
// Operand and result channel of the fp32 add/compare unit. The master side
// issues operands and consumes results; the unit itself is the slave.
interface fp32_add_cmp_pipe_if;

    logic [31:0] s_axis_a_tdata;
    logic [31:0] s_axis_b_tdata;
    logic        s_axis_a_tvalid;
    logic        s_axis_b_tvalid;
    logic [1:0]  s_axis_op;
    logic        m_axis_result_tvalid;
    logic [31:0] m_axis_result_tdata;

    modport master (
        output s_axis_a_tdata,
        output s_axis_b_tdata,
        output s_axis_a_tvalid,
        output s_axis_b_tvalid,
        output s_axis_op,
        input  m_axis_result_tvalid,
        input  m_axis_result_tdata
    );

    modport slave (
        input  s_axis_a_tdata,
        input  s_axis_b_tdata,
        input  s_axis_a_tvalid,
        input  s_axis_b_tvalid,
        input  s_axis_op,
        output m_axis_result_tvalid,
        output m_axis_result_tdata
    );

endinterface

// File: rtl/fp32_compare.sv
// Combinational equal / less-than on binary32 operands. Subnormals compare as
// zero, +0 equals -0, and any NaN forces both results low.
module fp32_compare
    import fp32_pkg::*;
(
    input  fp32_t a,
    input  fp32_t b,
    output logic  eq,
    output logic  lt
);

    // Resolve NaN and zero cases first, then order by sign and magnitude.
    always_comb begin
        eq = 1'b0;
        lt = 1'b0;
        if (is_nan(a) || is_nan(b)) begin
            eq = 1'b0;
            lt = 1'b0;
        end else if (is_zero(a) && is_zero(b)) begin
            eq = 1'b1;
        end else if (is_zero(a)) begin
            lt = !b.sign;
        end else if (is_zero(b)) begin
            lt = a.sign;
        end else if (a.sign != b.sign) begin
            lt = a.sign;
        end else begin
            eq = (a == b);
            lt = a.sign ? ({a.exp, a.man} > {b.exp, b.man})
                        : ({a.exp, a.man} < {b.exp, b.man});
        end
    end

endmodule

// File: rtl/fp32_add_cmp_pipe.sv
// Fully pipelined binary32 add / equal / less-than unit with a fixed latency
// of LATENCY cycles (legal 4..16) for every op. Three computing stages feed a
// round/pack step whose result enters a delay line; the last delay register
// drives the result channel, so in-order, gap-preserving timing falls out.
module fp32_add_cmp_pipe
    import fp32_pkg::*;
#(
    parameter int LATENCY = 11
) (
    input logic               aclk,
    input logic               aresetn,
    fp32_add_cmp_pipe_if.slave axis
);

    localparam int DLY = LATENCY - 3;

    // ---------------- stage A: unpack, classify, compare, swap ----------------
    fp32_t      a_in, b_in;
    fp_op_e     op_in;
    logic       accept;
    logic       eq_in, lt_in;
    logic       spec_in;
    logic [31:0] spec_val_in;
    logic       a_big;
    logic       big_sign;
    logic [7:0] big_exp, sm_exp;
    logic [22:0] big_man, sm_man;

    assign a_in   = axis.s_axis_a_tdata;
    assign b_in   = axis.s_axis_b_tdata;
    assign op_in  = fp_op_e'(axis.s_axis_op);
    assign accept = axis.s_axis_a_tvalid & axis.s_axis_b_tvalid;

    fp32_compare u_compare (
        .a  (a_in),
        .b  (b_in),
        .eq (eq_in),
        .lt (lt_in)
    );

    assign a_big    = {a_in.exp, a_in.man} >= {b_in.exp, b_in.man};
    assign big_sign = a_big ? a_in.sign : b_in.sign;
    assign big_exp  = a_big ? a_in.exp  : b_in.exp;
    assign big_man  = a_big ? a_in.man  : b_in.man;
    assign sm_exp   = a_big ? b_in.exp  : a_in.exp;
    assign sm_man   = a_big ? b_in.man  : a_in.man;

    // Sums fully decided by NaN, infinity or zero operands bypass the datapath.
    always_comb begin
        spec_in     = 1'b1;
        spec_val_in = 32'd0;
        if (is_nan(a_in) || is_nan(b_in)) begin
            spec_val_in = QNAN;
        end else if (is_inf(a_in) && is_inf(b_in)) begin
            spec_val_in = (a_in.sign != b_in.sign) ? QNAN : a_in;
        end else if (is_inf(a_in)) begin
            spec_val_in = a_in;
        end else if (is_inf(b_in)) begin
            spec_val_in = b_in;
        end else if (is_zero(a_in) && is_zero(b_in)) begin
            spec_val_in = {a_in.sign & b_in.sign, 31'd0};
        end else if (is_zero(a_in)) begin
            spec_val_in = b_in;
        end else if (is_zero(b_in)) begin
            spec_val_in = a_in;
        end else begin
            spec_in = 1'b0;
        end
    end

    logic        s1_valid, s1_eq, s1_lt, s1_spec, s1_sign, s1_eff_sub;
    fp_op_e      s1_op;
    logic [31:0] s1_spec_val;
    logic [7:0]  s1_exp, s1_diff;
    logic [23:0] s1_big_mant, s1_sm_mant;

    // Capture the accepted operation with the larger magnitude operand first.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s1_valid    <= 1'b0;
            s1_op       <= OP_ADD;
            s1_eq       <= 1'b0;
            s1_lt       <= 1'b0;
            s1_spec     <= 1'b0;
            s1_spec_val <= '0;
            s1_sign     <= 1'b0;
            s1_eff_sub  <= 1'b0;
            s1_exp      <= '0;
            s1_diff     <= '0;
            s1_big_mant <= '0;
            s1_sm_mant  <= '0;
        end else begin
            s1_valid    <= accept;
            s1_op       <= op_in;
            s1_eq       <= eq_in;
            s1_lt       <= lt_in;
            s1_spec     <= spec_in;
            s1_spec_val <= spec_val_in;
            s1_sign     <= big_sign;
            s1_eff_sub  <= a_in.sign ^ b_in.sign;
            s1_exp      <= big_exp;
            s1_diff     <= big_exp - sm_exp;
            s1_big_mant <= {1'b1, big_man};
            s1_sm_mant  <= {1'b1, sm_man};
        end
    end

    // ---------------- stage B: align with sticky, 27-bit add/sub ----------------
    logic [4:0]  shamt;
    logic [53:0] sm_wide;
    logic [26:0] sm_aligned;
    logic [27:0] big_ext, sum_b;

    assign shamt      = (s1_diff > 8'd27) ? 5'd27 : s1_diff[4:0];
    assign sm_wide    = {s1_sm_mant, 3'b000, 27'd0} >> shamt;
    assign sm_aligned = {sm_wide[53:28], sm_wide[27] | (|sm_wide[26:0])};
    assign big_ext    = {1'b0, s1_big_mant, 3'b000};
    assign sum_b      = s1_eff_sub ? (big_ext - {1'b0, sm_aligned})
                                   : (big_ext + {1'b0, sm_aligned});

    logic        s2_valid, s2_eq, s2_lt, s2_spec, s2_sign;
    fp_op_e      s2_op;
    logic [31:0] s2_spec_val;
    logic [7:0]  s2_exp;
    logic [27:0] s2_sum;

    // Register the raw magnitude sum; it is never negative after the swap.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s2_valid    <= 1'b0;
            s2_op       <= OP_ADD;
            s2_eq       <= 1'b0;
            s2_lt       <= 1'b0;
            s2_spec     <= 1'b0;
            s2_spec_val <= '0;
            s2_sign     <= 1'b0;
            s2_exp      <= '0;
            s2_sum      <= '0;
        end else begin
            s2_valid    <= s1_valid;
            s2_op       <= s1_op;
            s2_eq       <= s1_eq;
            s2_lt       <= s1_lt;
            s2_spec     <= s1_spec;
            s2_spec_val <= s1_spec_val;
            s2_sign     <= s1_sign;
            s2_exp      <= s1_exp;
            s2_sum      <= sum_b;
        end
    end

    // ---------------- stage C: leading-zero count and normalize ----------------
    logic [4:0]        lz;
    logic              lz_found;
    logic [26:0]       norm_c;
    logic signed [9:0] exp_c;

    // Find the leading one below the carry bit.
    always_comb begin
        lz       = 5'd0;
        lz_found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!lz_found && s2_sum[i]) begin
                lz       = 5'(26 - i);
                lz_found = 1'b1;
            end
        end
    end

    // A carry-out shifts right keeping sticky; otherwise shift left by the count.
    always_comb begin
        if (s2_sum[27]) begin
            norm_c = {s2_sum[27:2], s2_sum[1] | s2_sum[0]};
            exp_c  = {2'b00, s2_exp} + 10'd1;
        end else begin
            norm_c = s2_sum[26:0] << lz;
            exp_c  = {2'b00, s2_exp} - {5'd0, lz};
        end
    end

    logic              s3_valid, s3_eq, s3_lt, s3_spec, s3_sign, s3_zero;
    fp_op_e            s3_op;
    logic [31:0]       s3_spec_val;
    logic signed [9:0] s3_exp;
    logic [26:0]       s3_norm;

    // Register the normalized mantissa with guard/round/sticky in its low bits.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s3_valid    <= 1'b0;
            s3_op       <= OP_ADD;
            s3_eq       <= 1'b0;
            s3_lt       <= 1'b0;
            s3_spec     <= 1'b0;
            s3_spec_val <= '0;
            s3_sign     <= 1'b0;
            s3_zero     <= 1'b0;
            s3_exp      <= '0;
            s3_norm     <= '0;
        end else begin
            s3_valid    <= s2_valid;
            s3_op       <= s2_op;
            s3_eq       <= s2_eq;
            s3_lt       <= s2_lt;
            s3_spec     <= s2_spec;
            s3_spec_val <= s2_spec_val;
            s3_sign     <= s2_sign;
            s3_zero     <= (s2_sum == '0);
            s3_exp      <= exp_c;
            s3_norm     <= norm_c;
        end
    end

    // ---------------- stage D: round-to-nearest-even, pack, select ----------------
    logic              rnd_up;
    logic [24:0]       mant_r;
    logic signed [9:0] exp_r;
    logic [22:0]       man_f;
    logic [31:0]       add_res, res_d;

    assign rnd_up = s3_norm[2] & (s3_norm[1] | s3_norm[0] | s3_norm[3]);
    assign mant_r = {1'b0, s3_norm[26:3]} + {24'd0, rnd_up};
    assign exp_r  = s3_exp + {9'd0, mant_r[24]};
    assign man_f  = mant_r[24] ? mant_r[23:1] : mant_r[22:0];

    // Exact cancellation gives +0, overflow saturates to Inf, underflow flushes.
    always_comb begin
        add_res = {s3_sign, exp_r[7:0], man_f};
        if (s3_spec) begin
            add_res = s3_spec_val;
        end else if (s3_zero) begin
            add_res = 32'd0;
        end else if (exp_r >= 10'sd255) begin
            add_res = {s3_sign, POS_INF[30:0]};
        end else if (exp_r <= 10'sd0) begin
            add_res = {s3_sign, 31'd0};
        end
    end

    // Pick the result word for the operation that travelled with the data.
    always_comb begin
        res_d = 32'd0;
        case (s3_op)
            OP_ADD:  res_d = add_res;
            OP_EQ:   res_d = {31'd0, s3_eq};
            OP_LT:   res_d = {31'd0, s3_lt};
            default: res_d = 32'd0;
        endcase
    end

    // ---------------- delay line to the fixed latency ----------------
    logic [DLY-1:0] dly_valid;
    logic [31:0]    dly_data [DLY];

    // Shift results toward the output; data only moves with valid so the last
    // delivered value is held through bubbles.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            dly_valid <= '0;
            for (int i = 0; i < DLY; i++) begin
                dly_data[i] <= '0;
            end
        end else begin
            dly_valid[0] <= s3_valid;
            if (s3_valid) begin
                dly_data[0] <= res_d;
            end
            for (int i = 1; i < DLY; i++) begin
                dly_valid[i] <= dly_valid[i-1];
                if (dly_valid[i-1]) begin
                    dly_data[i] <= dly_data[i-1];
                end
            end
        end
    end

    assign axis.m_axis_result_tvalid = dly_valid[DLY-1];
    assign axis.m_axis_result_tdata  = dly_data[DLY-1];

endmodule

// File: tb/tb_fp32_add_cmp_pipe.sv
// Directed bench for fp32_add_cmp_pipe: hand-computed vectors, bubbles in a
// mixed stream, and asynchronous reset with operations in flight.
module tb_fp32_add_cmp_pipe;

    localparam int LAT = 11;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;

    always #5 aclk = ~aclk;

    fp32_add_cmp_pipe_if axis_if ();

    fp32_add_cmp_pipe #(.LATENCY(LAT)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .axis    (axis_if)
    );

    int cyc     = 0;
    int n_total = 0;
    int n_pass  = 0;

    always @(posedge aclk) cyc = cyc + 1;

    int          due_q [$];
    logic [31:0] val_q [$];
    string       tag_q [$];

    logic [31:0] vec_a [$];
    logic [31:0] vec_b [$];
    logic [31:0] vec_e [$];
    logic [1:0]  vec_op [$];
    string       vec_tag [$];

    task automatic addVec(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e);
        vec_tag.push_back(tag);
        vec_op.push_back(op);
        vec_a.push_back(a);
        vec_b.push_back(b);
        vec_e.push_back(e);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] expv);
        n_total++;
        if (obs !== expv) begin
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
                     tag, obs, expv, cyc);
        end else begin
            n_pass++;
        end
    endtask

    task automatic checkCycle();
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            checkOutput({tag_q[0], "_valid"}, {31'd0, axis_if.m_axis_result_tvalid}, 32'd1);
            checkOutput(tag_q[0], axis_if.m_axis_result_tdata, val_q[0]);
            void'(due_q.pop_front());
            void'(val_q.pop_front());
            void'(tag_q.pop_front());
        end else begin
            checkOutput("idle_valid", {31'd0, axis_if.m_axis_result_tvalid}, 32'd0);
        end
    endtask

    task automatic driveOp(input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] op, input logic va, input logic vb,
                           input logic [31:0] expv, input string tag);
        axis_if.s_axis_a_tdata  = a;
        axis_if.s_axis_b_tdata  = b;
        axis_if.s_axis_op       = op;
        axis_if.s_axis_a_tvalid = va;
        axis_if.s_axis_b_tvalid = vb;
        if (va && vb) begin
            due_q.push_back(cyc + LAT);
            val_q.push_back(expv);
            tag_q.push_back(tag);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] op, input logic va, input logic vb,
                                 input logic [31:0] expv, input string tag);
        @(negedge aclk);
        checkCycle();
        driveOp(a, b, op, va, vb, expv, tag);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(32'd0, 32'd0, 2'd0, 1'b0, 1'b0, 32'd0, "bubble");
        end
    endtask

    task automatic applyVec(input int k, input logic vb);
        applyStimulus(vec_a[k], vec_b[k], vec_op[k], 1'b1, vb, vec_e[k], vec_tag[k]);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        addVec("add_1p2",      2'd0, 32'h3F800000, 32'h40000000, 32'h40400000);
        addVec("add_cancel",   2'd0, 32'h3F800000, 32'hBF800000, 32'h00000000);
        addVec("rnd_tie_even", 2'd0, 32'h3F800000, 32'h33800000, 32'h3F800000);
        addVec("rnd_above",    2'd0, 32'h3F800000, 32'h33800001, 32'h3F800001);
        addVec("rnd_tie_odd",  2'd0, 32'h3F800001, 32'h33800000, 32'h3F800002);
        addVec("add_ovf",      2'd0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
        addVec("inf_minus",    2'd0, 32'h7F800000, 32'hFF800000, 32'h7FC00000);
        addVec("nan_in",       2'd0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000);
        addVec("subn_add",     2'd0, 32'h00000001, 32'h00000000, 32'h00000000);
        addVec("negz_negz",    2'd0, 32'h80000000, 32'h80000000, 32'h80000000);
        addVec("posz_negz",    2'd0, 32'h00000000, 32'h80000000, 32'h00000000);
        addVec("sub_3m2",      2'd0, 32'h40400000, 32'hC0000000, 32'h3F800000);
        addVec("neg2_p1",      2'd0, 32'hC0000000, 32'h3F800000, 32'hBF800000);
        addVec("inf_fin",      2'd0, 32'h7F800000, 32'h3F800000, 32'h7F800000);
        addVec("ninf_ninf",    2'd0, 32'hFF800000, 32'hFF800000, 32'hFF800000);
        addVec("eq_zeros",     2'd1, 32'h00000000, 32'h80000000, 32'h00000001);
        addVec("eq_nan",       2'd1, 32'h7FC00000, 32'h7FC00000, 32'h00000000);
        addVec("eq_subn",      2'd1, 32'h00000001, 32'h80000000, 32'h00000001);
        addVec("eq_one",       2'd1, 32'h3F800000, 32'h3F800000, 32'h00000001);
        addVec("eq_diff",      2'd1, 32'h3F800000, 32'h40000000, 32'h00000000);
        addVec("lt_m1_p1",     2'd2, 32'hBF800000, 32'h3F800000, 32'h00000001);
        addVec("lt_nz_pz",     2'd2, 32'h80000000, 32'h00000000, 32'h00000000);
        addVec("lt_nan",       2'd2, 32'h3F800000, 32'h7FC00000, 32'h00000000);
        addVec("lt_ninf",      2'd2, 32'hFF800000, 32'h3F800000, 32'h00000001);
        addVec("lt_neg",       2'd2, 32'hC0000000, 32'hBF800000, 32'h00000001);
        addVec("lt_2_1",       2'd2, 32'h40000000, 32'h3F800000, 32'h00000000);
        addVec("op_rsvd",      2'd3, 32'h3F800000, 32'h40000000, 32'h00000000);

        driveOp(32'd0, 32'd0, 2'd0, 1'b0, 1'b0, 32'd0, "bubble");

        // Reset state while held in reset.
        repeat (2) @(negedge aclk);
        checkOutput("rst_valid", {31'd0, axis_if.m_axis_result_tvalid}, 32'd0);
        checkOutput("rst_data", axis_if.m_axis_result_tdata, 32'd0);
        aresetn = 1'b1;

        // Directed vectors issued back to back.
        for (int k = 0; k < vec_a.size(); k++) begin
            applyVec(k, 1'b1);
        end
        idleCycles(LAT + 2);

        // Mixed stream where every third cycle carries only operand A.
        for (int i = 0; i < 20; i++) begin
            applyVec((i * 7) % vec_a.size(), (i % 3) != 2);
        end
        idleCycles(LAT + 2);

        // Reset with operations in flight, the oldest just reaching the output.
        for (int k = 0; k < 5; k++) begin
            applyVec(k, 1'b1);
        end
        idleCycles(LAT - 5);
        @(posedge aclk);
        #2;
        aresetn = 1'b0;
        #1;
        checkOutput("async_rst_valid", {31'd0, axis_if.m_axis_result_tvalid}, 32'd0);
        checkOutput("async_rst_data", axis_if.m_axis_result_tdata, 32'd0);
        due_q.delete();
        val_q.delete();
        tag_q.delete();
        driveOp(32'd0, 32'd0, 2'd0, 1'b0, 1'b0, 32'd0, "bubble");
        repeat (3) @(negedge aclk);
        checkOutput("rst_hold_valid", {31'd0, axis_if.m_axis_result_tvalid}, 32'd0);

        // Release and issue on the very first edge; no stale result may appear.
        aresetn = 1'b1;
        driveOp(32'h40400000, 32'hC0000000, 2'd0, 1'b1, 1'b1, 32'h3F800000, "post_rst_add");
        idleCycles(LAT + 3);

        checkOutput("sb_empty", 32'(due_q.size()), 32'd0);

        $display("[TB] %0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fp32_add_cmp_pipe.md
Name: fp32_add_cmp_pipe

Overview:
- Fully pipelined single-precision (IEEE-754 binary32) arithmetic/compare unit. One operation per cycle, fixed latency, no backpressure.
- Provides add, equal and less-than behind one AXI-stream-style result channel.
- Backs the vector helpers (dot-product adders, delay-only "+0" stages, comparators). Those helpers depend on fixed, known latency so side pipelines can be matched.

Parameters:
- LATENCY, 11, cycles from input accept to result valid. Legal range 4..16, identical for all ops.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- s_axis_a_tdata  in  32  operand A, binary32.
- s_axis_b_tdata  in  32  operand B, binary32.
- s_axis_a_tvalid  in  1  operand A valid.
- s_axis_b_tvalid  in  1  operand B valid.
- s_axis_op  in  2  operation select: 0 = add, 1 = equal, 2 = less-than (A<B), 3 = reserved.
- m_axis_result_tvalid  out  1  result valid.
- m_axis_result_tdata  out  32  add: binary32 sum. Compare: bit0 = result, bits 31:1 = 0.

Behaviour:
- Accept condition: s_axis_a_tvalid & s_axis_b_tvalid in a cycle. Operands and op are captured that cycle. Any other cycle inserts a bubble.
- There is no tready; the unit always accepts.
- Each accepted operation produces exactly one result, with m_axis_result_tvalid=1 exactly LATENCY cycles later. Results stay in order and back-to-back issue gives back-to-back results.
- m_axis_result_tdata is don't-care when tvalid=0. The implementation holds the last value.
- Reset asserted: all pipeline valid bits and m_axis_result_tvalid clear to 0 and m_axis_result_tdata clears to 0, asynchronously.
- Reset mid-operation: all in-flight operations are dropped and no results appear for them after release.
- First accept is possible on the first rising edge after aresetn deasserts.
- Add, general: round-to-nearest-even.
- Add, subnormals: subnormal inputs are treated as signed zero; subnormal or underflowing results flush to signed zero.
- Add, zero signs: exact cancellation x + (-x) = +0; (-0) + (-0) = -0; (+0) + (-0) = +0.
- Add, overflow: a result exceeding the max finite value gives signed infinity 0x7F800000 / 0xFF800000.
- Add, infinities: Inf + finite = Inf. Inf + Inf (same sign) = that Inf. +Inf + -Inf = canonical qNaN 0x7FC00000.
- Add, NaN: any NaN input gives 0x7FC00000; payloads are not propagated.
- Equal: 1 iff both operands are non-NaN and numerically equal. +0 == -0 (also subnormal vs zero). Any NaN gives 0.
- Less-than: 1 iff both operands are non-NaN and A < B numerically. -0 < +0 is 0. -Inf < any finite is 1. Any NaN gives 0.
- Op 3: result tdata = 0 with valid asserted normally.
- Pipeline structure for add:
  - unpack/classify;
  - exponent compare and swap;
  - align shift with sticky;
  - add/sub 27-bit mantissa;
  - leading-zero count and normalize;
  - round and pack.
- Comparisons are computed early and delay-matched to LATENCY.
- Stage registers are padded with delay stages so every op uses exactly LATENCY.

Decomposition:
- Package fp32_pkg:
  - EXP_W=8, MAN_W=23, BIAS=127;
  - QNAN=32'h7FC00000, POS_INF=32'h7F800000;
  - op enum (OP_ADD, OP_EQ, OP_LT, OP_RSVD);
  - struct {sign, exp, man} with classify helpers is_nan/is_inf/is_zero (subnormal counts as zero).
- Natural sub-module: fp32_compare. It is combinational eq/lt from unpacked operands and is instantiated once ahead of the delay line.

Test Plan:
- Basic add: A=0x3F800000, B=0x40000000, op=0 -> 0x40400000 exactly LATENCY cycles later. Then 0x3F800000 + 0xBF800000 -> 0x00000000.
- Rounding: 0x3F800000 + 0x33800000 -> 0x3F800000 (tie to even). 0x3F800000 + 0x33800001 -> 0x3F800001.
- Specials: 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000. 0x7F800000 + 0xFF800000 -> 0x7FC00000. 0x7FC00001 + 0x3F800000 -> 0x7FC00000. Subnormal 0x00000001 + 0x00000000 -> 0x00000000.
- Compares:
  - equal(0x00000000, 0x80000000) -> 1;
  - equal(0x7FC00000, 0x7FC00000) -> 0;
  - lt(0xBF800000, 0x3F800000) -> 1;
  - lt(0x80000000, 0x00000000) -> 0;
  - lt(0x3F800000, 0x7FC00000) -> 0.
- Streaming: 20 consecutive mixed ops with only A valid on every third cycle. Required: exactly the accepted ops return, in order, at fixed LATENCY, and valid gaps match input gaps.
- Reset: assert aresetn=0 with 5 ops in flight. Required: tvalid=0 immediately (asynchronous) and tdata=0. After release, no stale results, and a new op returns after LATENCY.
